// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state encoding, activation codes and defaults for the MLP layer sequencer
package mlp_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_READ   = 3'd3,
      S_CMP    = 3'd4
   } seq_state_t;

   localparam logic [1:0] ACT_LINEAR = 2'd0;
   localparam logic [1:0] ACT_RELU   = 2'd1;

   localparam int         DEF_DW      = 16;
   localparam logic [5:0] DEF_ACT_CFG = {ACT_LINEAR, ACT_RELU, ACT_RELU};

endpackage

// File: rtl/mlp_seq_watchdog.sv
// rtl/mlp_seq_watchdog.sv - per-layer cycle counter and expiry compare
// Built into the sequencer only when MLP_SEQ_WATCHDOG_EN is defined.
module mlp_seq_watchdog #(
   parameter int TIMEOUT_CYC = 4096
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != LIMIT)
         cnt <= cnt + 1'b1;
   end

   // err is registered in the sequencer, so expiry is flagged one cycle early
   // to land the err pulse TIMEOUT_CYC cycles after layer_start.
   assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - runs an MLP inference layer by layer on a shared dense-layer engine
// Optional per-layer watchdog enabled with MLP_SEQ_WATCHDOG_EN.
module mlp_layer_sequencer
   import mlp_pkg::*;
#(
   parameter int                          NUM_LAYERS  = 3,
   parameter int                          LIDX_W      = 2,
   parameter int                          DW          = DEF_DW,
   parameter logic [2*NUM_LAYERS-1:0]     ACT_CFG     = DEF_ACT_CFG,
   parameter int                          TIMEOUT_CYC = 4096
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DW-1:0]     threshold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              anomaly,
   output logic [DW-1:0]     score,
   output logic              layer_start,
   output logic [1:0]        layer_act_sel,
   output logic [LIDX_W-1:0] layer_idx,
   input  logic              layer_done,
   output logic              bank_sel,
   output logic              res_cs,
   output logic [4:0]        res_addr,
   input  logic [DW-1:0]     res_dout
);

   localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

   seq_state_t        state, state_n;
   logic [DW-1:0]     threshold_q, threshold_n;
   logic [DW-1:0]     score_n;
   logic              anomaly_n, busy_n, done_n, err_n, bank_n;
   logic [LIDX_W-1:0] idx_n;
   logic [1:0]        act_n;
   logic              wd_expired;

`ifdef MLP_SEQ_WATCHDOG_EN
   mlp_seq_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == S_LAUNCH),
      .en      (state == S_WAIT),
      .expired (wd_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC != 0);
   assign wd_expired     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         threshold_q   <= '0;
         score         <= '0;
         anomaly       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         bank_sel      <= 1'b0;
         layer_idx     <= '0;
         layer_act_sel <= ACT_LINEAR;
      end else begin
         state         <= state_n;
         threshold_q   <= threshold_n;
         score         <= score_n;
         anomaly       <= anomaly_n;
         busy          <= busy_n;
         done          <= done_n;
         err           <= err_n;
         bank_sel      <= bank_n;
         layer_idx     <= idx_n;
         layer_act_sel <= act_n;
      end
   end

   always_comb begin
      state_n     = state;
      threshold_n = threshold_q;
      score_n     = score;
      anomaly_n   = anomaly;
      busy_n      = busy;
      done_n      = 1'b0;
      err_n       = 1'b0;
      bank_n      = bank_sel;
      idx_n       = layer_idx;
      act_n       = layer_act_sel;

      if (abort && state != S_IDLE) begin
         state_n = S_IDLE;
         busy_n  = 1'b0;
         err_n   = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  threshold_n = threshold;
                  idx_n       = '0;
                  bank_n      = 1'b0;
                  busy_n      = 1'b1;
                  act_n       = ACT_CFG[1:0];
                  state_n     = S_LAUNCH;
               end
            end
            S_LAUNCH: state_n = S_WAIT;
            S_WAIT: begin
               // act_sel is loaded on entry to LAUNCH so it is already stable with layer_start
               if (layer_done) begin
                  if (layer_idx == LAST_IDX) begin
                     state_n = S_READ;
                  end else begin
                     idx_n   = layer_idx + 1'b1;
                     bank_n  = ~bank_sel;
                     act_n   = ACT_CFG[{idx_n, 1'b0} +: 2];
                     state_n = S_LAUNCH;
                  end
               end else if (wd_expired) begin
                  state_n = S_IDLE;
                  busy_n  = 1'b0;
                  err_n   = 1'b1;
               end
            end
            S_READ: state_n = S_CMP;
            S_CMP: begin
               score_n   = res_dout;
               anomaly_n = ($signed(res_dout) > $signed(threshold_q));
               done_n    = 1'b1;
               busy_n    = 1'b0;
               state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign layer_start = (state == S_LAUNCH);
   assign res_cs      = (state == S_READ);
   assign res_addr    = 5'd0;

endmodule
